// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back path.
//   REG_W    : register data width
//   ADDR_W   : register address width
//   NUM_REGS : number of architectural registers
//   wb_req_t : one pending register write {rd, data}
//   writes_reg() : true when a write to rd actually modifies the register file
//                  (r0 is hard-wired to zero, so writes to it are dropped)
package regfile_pkg;

    localparam int REG_W    = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [REG_W-1:0]  data;
    } wb_req_t;

    function automatic logic writes_reg(input logic [ADDR_W-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if.sv
// Bundle of the write-back arbiter's request/response and register-file
// write-port signals.
//   alu_valid/alu_rd/alu_data/alu_ready : ALU write request handshake
//   md_valid/md_rd/md_data/md_ready     : multdiv write request handshake
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg : register-file write port
//   md_pending                          : multdiv FIFO non-empty
// Optional feature macro: WB_FWD_EN adds ctrl_readRegA/B (to arbiter) and
// fwd_hitA/fwd_hitB/fwd_data (from arbiter) for write-port bypass.
// Modports: slave = arbiter view, master = datapath/register-file view.
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [REG_W-1:0]  alu_data;
    logic              alu_ready;
    logic              md_valid;
    logic [ADDR_W-1:0] md_rd;
    logic [REG_W-1:0]  md_data;
    logic              md_ready;
    logic              ctrl_writeEnable;
    logic [ADDR_W-1:0] ctrl_writeReg;
    logic [REG_W-1:0]  data_writeReg;
    logic              md_pending;
`ifdef WB_FWD_EN
    logic [ADDR_W-1:0] ctrl_readRegA;
    logic [ADDR_W-1:0] ctrl_readRegB;
    logic              fwd_hitA;
    logic              fwd_hitB;
    logic [REG_W-1:0]  fwd_data;

    modport slave (
        input  alu_valid, alu_rd, alu_data, md_valid, md_rd, md_data,
        input  ctrl_readRegA, ctrl_readRegB,
        output alu_ready, md_ready, ctrl_writeEnable, ctrl_writeReg,
        output data_writeReg, md_pending, fwd_hitA, fwd_hitB, fwd_data
    );
    modport master (
        output alu_valid, alu_rd, alu_data, md_valid, md_rd, md_data,
        output ctrl_readRegA, ctrl_readRegB,
        input  alu_ready, md_ready, ctrl_writeEnable, ctrl_writeReg,
        input  data_writeReg, md_pending, fwd_hitA, fwd_hitB, fwd_data
    );
`else
    modport slave (
        input  alu_valid, alu_rd, alu_data, md_valid, md_rd, md_data,
        output alu_ready, md_ready, ctrl_writeEnable, ctrl_writeReg,
        output data_writeReg, md_pending
    );
    modport master (
        output alu_valid, alu_rd, alu_data, md_valid, md_rd, md_data,
        input  alu_ready, md_ready, ctrl_writeEnable, ctrl_writeReg,
        input  data_writeReg, md_pending
    );
`endif

endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// regfile_wb_arbiter_fifo.sv (module wb_fifo)
// DEPTH-entry synchronous FIFO of wb_req_t holding multdiv results.
//   clock, ctrl_reset : clock and synchronous active-high flush
//   push, push_req    : enqueue at tail (caller guarantees not full)
//   pop               : dequeue head (caller guarantees not empty)
//   head              : current head entry (valid when count != 0)
//   count             : number of occupied entries, 0..DEPTH
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     ctrl_reset,
    input  logic                     push,
    input  wb_req_t                  push_req,
    input  logic                     pop,
    output wb_req_t                  head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    // Storage carries no reset; only pointers and count are flushed.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_req;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter.sv
// Merges ALU and multdiv destination-register writes onto the register
// file's single write port. ALU requests issue directly; multdiv results are
// queued in wb_fifo and drained into cycles the ALU leaves idle. A starvation
// counter drops alu_ready for one cycle once the queue head has waited
// STARVE_LIMIT cycles, forcing the head out.
//   clock, ctrl_reset : clock, synchronous active-high reset
//   wb (slave)        : request handshakes, write port, md_pending
// Optional feature macro: WB_FWD_EN enables combinational forwarding of the
// registered write port to two read addresses (fwd_hitA/B, fwd_data).
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    regfile_wb_arbiter_if.slave   wb
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [CW-1:0]     fifo_count;
    wb_req_t           fifo_head;
    wb_req_t           md_req;
    logic [SW-1:0]     starve_cnt;
    logic              fifo_empty;
    logic              md_push;
    logic              issue_alu;
    logic              issue_md;
    logic              issue_any;
    wb_req_t           issue_req;
    logic              we_p1;
    logic [ADDR_W-1:0] rd_p1;
    logic [REG_W-1:0]  data_p1;

    assign md_req.rd   = wb.md_rd;
    assign md_req.data = wb.md_data;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .push       (md_push),
        .push_req   (md_req),
        .pop        (issue_md),
        .head       (fifo_head),
        .count      (fifo_count)
    );

    // Ready signals come only from registered state. A full FIFO refuses
    // input even if the head leaves this cycle.
    assign fifo_empty    = (fifo_count == '0);
    assign wb.md_ready   = (fifo_count < FULL_CNT);
    assign wb.alu_ready  = (starve_cnt != STARVE_MAX);
    assign wb.md_pending = !fifo_empty;

    assign md_push   = wb.md_valid & wb.md_ready;
    assign issue_alu = wb.alu_valid & wb.alu_ready;
    assign issue_md  = !issue_alu & !fifo_empty;
    assign issue_any = issue_alu | issue_md;

    always_comb begin
        issue_req = fifo_head;
        if (issue_alu) begin
            issue_req.rd   = wb.alu_rd;
            issue_req.data = wb.alu_data;
        end
    end

    // Counts cycles the queued head is passed over; held at the limit so
    // alu_ready stays low until the head actually issues.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            starve_cnt <= '0;
        end else if (fifo_empty || issue_md) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // ---- issue (p0) -> write port (p1) ----
    // A write to r0 still consumes the slot but never asserts the enable.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            we_p1   <= 1'b0;
            rd_p1   <= '0;
            data_p1 <= '0;
        end else begin
            we_p1 <= issue_any & writes_reg(issue_req.rd);
            if (issue_any) begin
                rd_p1   <= issue_req.rd;
                data_p1 <= issue_req.data;
            end
        end
    end

    assign wb.ctrl_writeEnable = we_p1;
    assign wb.ctrl_writeReg    = rd_p1;
    assign wb.data_writeReg    = data_p1;

`ifdef WB_FWD_EN
    assign wb.fwd_hitA = we_p1 & (rd_p1 == wb.ctrl_readRegA) & (wb.ctrl_readRegA != '0);
    assign wb.fwd_hitB = we_p1 & (rd_p1 == wb.ctrl_readRegB) & (wb.ctrl_readRegB != '0);
    assign wb.fwd_data = data_p1;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter (DEPTH=4,
// STARVE_LIMIT=8), plus hand sequences for starvation, reset flush and,
// when WB_FWD_EN is defined, write-port forwarding.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic clock = 1'b0;
    logic ctrl_reset = 1'b1;
    always #5 clock = ~clock;

    regfile_wb_arbiter_if wb_if();

    regfile_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .wb         (wb_if)
    );

    typedef struct {
        logic        alu_valid;
        logic [4:0]  alu_rd;
        logic [31:0] alu_data;
        logic        md_valid;
        logic [4:0]  md_rd;
        logic [31:0] md_data;
        logic        exp_we;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
        logic        exp_pend;
        logic        exp_mdr;
        logic        exp_ar;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;
    vec_t vecs [15];

    function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] ad,
                                logic mv, logic [4:0] mrd, logic [31:0] md,
                                logic we, logic [4:0] rg, logic [31:0] dt,
                                logic pend, logic mdr, logic ar);
        vec_t v;
        v.alu_valid = av; v.alu_rd = ard; v.alu_data = ad;
        v.md_valid = mv;  v.md_rd = mrd;  v.md_data = md;
        v.exp_we = we; v.exp_reg = rg; v.exp_data = dt;
        v.exp_pend = pend; v.exp_mdr = mdr; v.exp_ar = ar;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        wb_if.alu_valid = av; wb_if.alu_rd = ard; wb_if.alu_data = ad;
        wb_if.md_valid  = mv; wb_if.md_rd  = mrd; wb_if.md_data  = md;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Write port is checked for rd/data only when a write is expected.
    task automatic chk_out(input string tag, input logic we, input logic [4:0] rg,
                           input logic [31:0] dt, input logic pend, input logic mdr,
                           input logic ar);
        chk({tag, ".we"}, 32'(wb_if.ctrl_writeEnable), 32'(we));
        if (we) begin
            chk({tag, ".reg"},  32'(wb_if.ctrl_writeReg), 32'(rg));
            chk({tag, ".data"}, wb_if.data_writeReg, dt);
        end
        chk({tag, ".pend"}, 32'(wb_if.md_pending), 32'(pend));
        chk({tag, ".mdr"},  32'(wb_if.md_ready),   32'(mdr));
        chk({tag, ".ar"},   32'(wb_if.alu_ready),  32'(ar));
    endtask

    initial begin
        int ar_low;
        drive(0, 0, 0, 1, 5'd9, 32'h9999);
`ifdef WB_FWD_EN
        wb_if.ctrl_readRegA = '0;
        wb_if.ctrl_readRegB = '0;
`endif
        // Reset held two cycles with a multdiv request present.
        ctrl_reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_out($sformatf("rst%0d", i), 0, 0, 0, 0, 1, 1);
            chk($sformatf("rst%0d.reg", i),  32'(wb_if.ctrl_writeReg), 32'd0);
            chk($sformatf("rst%0d.data", i), wb_if.data_writeReg, 32'd0);
        end
        ctrl_reset = 1'b0;

        //           alu: v rd data          md: v rd data        exp: we rg data   pend mdr ar
        vecs[0]  = mk(1, 5,  32'hDEADBEEF,  0, 0, 32'h0,          1, 5, 32'hDEADBEEF, 0, 1, 1);
        vecs[1]  = mk(1, 0,  32'h00001234,  0, 0, 32'h0,          0, 0, 32'h0,        0, 1, 1);
        vecs[2]  = mk(1, 3,  32'h00000033,  1, 1, 32'h101,        1, 3, 32'h33,       1, 1, 1);
        vecs[3]  = mk(1, 4,  32'h00000044,  1, 2, 32'h102,        1, 4, 32'h44,       1, 1, 1);
        vecs[4]  = mk(1, 6,  32'h00000066,  1, 3, 32'h103,        1, 6, 32'h66,       1, 1, 1);
        vecs[5]  = mk(1, 8,  32'h00000088,  1, 4, 32'h104,        1, 8, 32'h88,       1, 0, 1);
        vecs[6]  = mk(1, 9,  32'h00000099,  1, 5, 32'h105,        1, 9, 32'h99,       1, 0, 1);
        vecs[7]  = mk(0, 0,  32'h0,         1, 5, 32'h105,        1, 1, 32'h101,      1, 1, 1);
        vecs[8]  = mk(0, 0,  32'h0,         1, 5, 32'h105,        1, 2, 32'h102,      1, 1, 1);
        vecs[9]  = mk(0, 0,  32'h0,         0, 0, 32'h0,          1, 3, 32'h103,      1, 1, 1);
        vecs[10] = mk(0, 0,  32'h0,         0, 0, 32'h0,          1, 4, 32'h104,      1, 1, 1);
        vecs[11] = mk(0, 0,  32'h0,         0, 0, 32'h0,          1, 5, 32'h105,      0, 1, 1);
        vecs[12] = mk(0, 0,  32'h0,         0, 0, 32'h0,          0, 0, 32'h0,        0, 1, 1);
        vecs[13] = mk(1, 7,  32'h0000000A,  1, 7, 32'h0B,         1, 7, 32'h0A,       1, 1, 1);
        vecs[14] = mk(0, 0,  32'h0,         0, 0, 32'h0,          1, 7, 32'h0B,       0, 1, 1);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].alu_valid, vecs[i].alu_rd, vecs[i].alu_data,
                  vecs[i].md_valid, vecs[i].md_rd, vecs[i].md_data);
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_reg,
                    vecs[i].exp_data, vecs[i].exp_pend, vecs[i].exp_mdr, vecs[i].exp_ar);
        end

        // Starvation: ALU valid every cycle with one queued multdiv entry.
        drive(1, 10, 32'h1000, 1, 11, 32'hABC);
        tick();
        chk_out("stv.enq", 1, 10, 32'h1000, 1, 1, 1);
        ar_low = 0;
        for (int i = 1; i <= 8; i++) begin
            drive(1, 12, 32'h2000 + 32'(i), 0, 0, 0);
            tick();
            chk_out($sformatf("stv%0d", i), 1, 12, 32'h2000 + 32'(i), 1, 1, (i != 8));
            if (!wb_if.alu_ready) ar_low++;
        end
        drive(1, 12, 32'h3000, 0, 0, 0);
        tick();
        chk_out("stv.drain", 1, 11, 32'hABC, 0, 1, 1);
        tick();
        chk_out("stv.resume", 1, 12, 32'h3000, 0, 1, 1);
        chk("stv.low_cycles", 32'(ar_low), 32'd1);

        // Reset while entries are queued flushes them.
        drive(1, 13, 32'h13, 1, 14, 32'h14);
        tick();
        drive(1, 15, 32'h15, 1, 16, 32'h16);
        tick();
        chk("flush.pre_pend", 32'(wb_if.md_pending), 32'd1);
        drive(1, 17, 32'h17, 1, 18, 32'h18);
        ctrl_reset = 1'b1;
        tick();
        chk_out("flush.rst", 0, 0, 0, 0, 1, 1);
        chk("flush.rst.reg",  32'(wb_if.ctrl_writeReg), 32'd0);
        chk("flush.rst.data", wb_if.data_writeReg, 32'd0);
        ctrl_reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk_out("flush.post", 0, 0, 0, 0, 1, 1);

`ifdef WB_FWD_EN
        drive(1, 7, 32'hCAFEF00D, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        wb_if.ctrl_readRegA = 5'd7;
        wb_if.ctrl_readRegB = 5'd0;
        #1;
        chk("fwd.hitA", 32'(wb_if.fwd_hitA), 32'd1);
        chk("fwd.hitB", 32'(wb_if.fwd_hitB), 32'd0);
        chk("fwd.data", wb_if.fwd_data, 32'hCAFEF00D);
        wb_if.ctrl_readRegA = 5'd6;
        #1;
        chk("fwd.missA", 32'(wb_if.fwd_hitA), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
